// File: rtl/usb_aes_pkg.sv
// Types and helpers shared by the USB AES datapath: packer state and the
// block-size constants.
package usb_aes_pkg;

  localparam int unsigned BLK_BYTES = 16;
  localparam int unsigned BLK_BITS  = 128;

  typedef enum logic [1:0] {
    StFill,
    StPad,
    StHold
  } pack_state_e;

  // PKCS#7 pad for a block holding `count` bytes; count 0 means an empty block.
  function automatic logic [7:0] pad_byte(input logic [3:0] count);
    logic [7:0] pad;
    pad = 8'd16 - {4'd0, count};
    return pad;
  endfunction

endpackage

// File: rtl/flex_full_counter.sv
// Free-running wrap-around counter with synchronous clear and count enable.
module flex_full_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clr,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/fifo_block_packer.sv
// Packs FIFO bytes MSB-first into 128-bit AES blocks with valid/ready output.
// PKCS7_PAD_EN selects PKCS#7 padding and a pad-only block on empty close.
module fifo_block_packer
  import usb_aes_pkg::*;
#(
  parameter int unsigned NUMBITS  = 8,
  parameter int unsigned BLKBYTES = 16,
  parameter int unsigned CNTBITS  = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        fifo_empty,
  input  logic [NUMBITS-1:0]          fifo_rdata,
  output logic                        fifo_r_enable,
  input  logic                        pkt_done,
  output logic [BLKBYTES*NUMBITS-1:0] blk_data,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic                        blk_last,
  output logic                        busy
);

  pack_state_e                 state_q, state_d;
  logic                        pend_q, pend_d;
  logic                        last_q, last_d;
  logic [BLKBYTES*NUMBITS-1:0] blk_q, blk_d;
  logic [CNTBITS-1:0]          count;
  logic                        handshake, close_cond, enter_pad, cnt_clr;
  logic [NUMBITS-1:0]          pad_val;

  assign fifo_r_enable = (state_q == StFill) && !fifo_empty;
  assign handshake     = (state_q == StHold) && blk_ready;
  // Remaining FIFO bytes still belong to the pending packet, so close only once drained.
  assign close_cond    = (state_q == StFill) && pend_q && fifo_empty;

`ifdef PKCS7_PAD_EN
  assign enter_pad = close_cond;
  assign pad_val   = pad_byte(count);
`else
  assign enter_pad = close_cond && (count != '0);
  assign pad_val   = '0;
`endif

  assign cnt_clr = handshake || (state_q == StPad);

  flex_full_counter #(
    .NUM_CNT_BITS(CNTBITS)
  ) u_byte_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clr         (cnt_clr),
    .count_enable(fifo_r_enable),
    .count_out   (count)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    last_d  = last_q;
    blk_d   = blk_q;

    if (!pend_q) begin
      pend_d = pkt_done;
    end else if (close_cond) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      StFill: begin
        if (fifo_r_enable) begin
          for (int unsigned i = 0; i < BLKBYTES; i++) begin
            if (CNTBITS'(i) == count) begin
              blk_d[(BLKBYTES-1-i)*NUMBITS +: NUMBITS] = fifo_rdata;
            end
          end
          if (count == CNTBITS'(BLKBYTES-1)) begin
            state_d = StHold;
            last_d  = 1'b0;
          end
        end else if (enter_pad) begin
          state_d = StPad;
        end
      end
      StPad: begin
        for (int unsigned i = 0; i < BLKBYTES; i++) begin
          if (CNTBITS'(i) >= count) begin
            blk_d[(BLKBYTES-1-i)*NUMBITS +: NUMBITS] = pad_val;
          end
        end
        last_d  = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (blk_ready) begin
          state_d = StFill;
          last_d  = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StFill;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      blk_q   <= blk_d;
    end
  end

  assign blk_data  = blk_q;
  assign blk_valid = (state_q == StHold);
  assign blk_last  = last_q;
  assign busy      = (state_q != StFill) || (count != '0) || pend_q;

endmodule
